// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data port and host preload port bundle
interface dmem_responder_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  // core data port
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;

  // host preload/dump port
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;

  modport master (
    output CEN, WEN, OEN, A, D, h_req, h_we, h_addr, h_wdata,
    input  Q, h_ack, h_rdata
  );

  modport slave (
    input  CEN, WEN, OEN, A, D, h_req, h_we, h_addr, h_wdata,
    output Q, h_ack, h_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory with core port, idle-cycle host port and access counters
module dmem_responder #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0] mem [DEPTH];

  state_t        state;
  state_t        state_next;

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic [DW-1:0] q_hold;
  logic [DW-1:0] q_mux;
  logic [DW-1:0] h_rdata_r;

  logic          core_rd;
  logic          core_wr;
  logic          core_bad_rd;
  logic          host_capture;
  logic          host_access;
  logic          host_wr;
  logic          host_rd;
  logic          ack;

  // decode the core request for this cycle
  always_comb begin
    core_rd     = !bus.CEN && bus.WEN;
    core_wr     = !bus.CEN && !bus.WEN;
    core_bad_rd = core_rd && bus.OEN;
  end

  // read data: live array data on an enabled read, zero on a bad read, else last read value
  always_comb begin
    q_mux = q_hold;
    if (core_rd) begin
      if (bus.OEN) begin
        q_mux = '0;
      end else begin
        q_mux = mem[bus.A];
      end
    end
  end

  assign bus.Q       = q_mux;
  assign bus.h_rdata = h_rdata_r;
  assign bus.h_ack   = ack;

  // host FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // host FSM next state; the core owns every cycle with CEN low
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.h_req) state_next = S_WAIT;
      S_WAIT: if (bus.CEN) state_next = S_ACK;
      S_ACK:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // host FSM outputs: capture strobe, array access strobes, ack pulse
  always_comb begin
    host_capture = 1'b0;
    host_access  = 1'b0;
    ack          = 1'b0;
    case (state)
      S_IDLE: host_capture = bus.h_req;
      S_WAIT: host_access  = bus.CEN;
      S_ACK:  ack          = 1'b1;
      default: begin
        host_capture = 1'b0;
        host_access  = 1'b0;
        ack          = 1'b0;
      end
    endcase
    host_wr = host_access && lat_we;
    host_rd = host_access && !lat_we;
  end

  // latch the host request when it is accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (host_capture) begin
      lat_we    <= bus.h_we;
      lat_addr  <= bus.h_addr;
      lat_wdata <= bus.h_wdata;
    end
  end

  // array writes; core and host are mutually exclusive by CEN so no arbitration is needed
  always_ff @(posedge clk) begin
    if (core_wr) begin
      mem[bus.A] <= bus.D;
    end else if (host_wr) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

  // host read data, held until the next host read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      h_rdata_r <= '0;
    end else if (host_rd) begin
      h_rdata_r <= mem[lat_addr];
    end
  end

  // remember the value returned by the last core read
  always_ff @(posedge clk) begin
    if (rst) begin
      q_hold <= '0;
    end else if (core_rd) begin
      q_hold <= q_mux;
    end
  end

  // saturating access counters and sticky error; clear beats same-cycle updates
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (core_rd && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
      if (core_wr && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
      if (core_bad_rd) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             clr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             err;

  int n_checks;
  int n_fail;

  dmem_responder_if #(.AW(AW), .DW(DW)) bus ();

  dmem_responder #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .clr_cnt (clr_cnt),
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; registered outputs are then stable
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    bus.CEN = 1'b1;
    bus.WEN = 1'b1;
    bus.OEN = 1'b1;
  endtask

  task automatic core_read(input logic [AW-1:0] a, input logic oen);
    bus.CEN = 1'b0;
    bus.WEN = 1'b1;
    bus.OEN = oen;
    bus.A   = a;
  endtask

  task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.CEN = 1'b0;
    bus.WEN = 1'b0;
    bus.OEN = 1'b1;
    bus.A   = a;
    bus.D   = d;
  endtask

  task automatic host_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.h_req   = 1'b1;
    bus.h_we    = we;
    bus.h_addr  = a;
    bus.h_wdata = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clr_cnt  = 1'b0;
    core_idle();
    bus.A       = '0;
    bus.D       = '0;
    bus.h_req   = 1'b0;
    bus.h_we    = 1'b0;
    bus.h_addr  = '0;
    bus.h_wdata = '0;

    // reset state
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_h_ack", 64'(bus.h_ack), 64'd0);
    check_eq("rst_h_rdata", 64'(bus.h_rdata), 64'd0);
    check_eq("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    check_eq("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_q", 64'(bus.Q), 64'd0);

    // host write mem[5] with the core idle: ack two cycles after h_req is sampled
    host_drive(1'b1, 7'd5, 32'hDEADBEEF);
    step();
    bus.h_req = 1'b0;
    check_eq("hw_ack_c1", 64'(bus.h_ack), 64'd0);
    step();
    check_eq("hw_ack_c2", 64'(bus.h_ack), 64'd1);
    step();
    check_eq("hw_ack_c3", 64'(bus.h_ack), 64'd0);

    // core read of the preloaded word, same-cycle data
    core_read(7'd5, 1'b0);
    #1;
    check_eq("rd5_q", 64'(bus.Q), 64'hDEADBEEF);
    step();
    core_idle();
    check_eq("rd5_rd_cnt", 64'(rd_cnt), 64'd1);

    // core write then read-back on the next cycle
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    core_write(7'd9, 32'h12345678);
    step();
    core_read(7'd9, 1'b0);
    #1;
    check_eq("rd9_q", 64'(bus.Q), 64'h12345678);
    step();
    core_idle();
    #1;
    check_eq("wr9_wr_cnt", 64'(wr_cnt), 64'd1);
    check_eq("rd9_rd_cnt", 64'(rd_cnt), 64'd1);
    check_eq("rd9_q_hold", 64'(bus.Q), 64'h12345678);

    // host read starved by six core cycles, then served on the first idle cycle
    core_read(7'd5, 1'b0);
    host_drive(1'b0, 7'd9, 32'h0);
    step();
    bus.h_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("starve_ack", 64'(bus.h_ack), 64'd0);
      step();
    end
    check_eq("starve_ack_last", 64'(bus.h_ack), 64'd0);
    core_idle();
    step();
    check_eq("hr_ack", 64'(bus.h_ack), 64'd1);
    check_eq("hr_rdata", 64'(bus.h_rdata), 64'h12345678);
    check_eq("hr_q_hold", 64'(bus.Q), 64'hDEADBEEF);
    step();
    check_eq("hr_ack_drop", 64'(bus.h_ack), 64'd0);
    check_eq("hr_rdata_hold", 64'(bus.h_rdata), 64'h12345678);

    // read with OEN high: zero data, sticky error, clear wins
    core_read(7'd5, 1'b1);
    #1;
    check_eq("bad_q", 64'(bus.Q), 64'd0);
    step();
    core_idle();
    #1;
    check_eq("bad_err", 64'(err), 64'd1);
    check_eq("bad_q_hold", 64'(bus.Q), 64'd0);
    step();
    check_eq("bad_err_sticky", 64'(err), 64'd1);
    clr_cnt = 1'b1;
    core_read(7'd5, 1'b1);
    step();
    clr_cnt = 1'b0;
    core_idle();
    check_eq("clr_rd_cnt", 64'(rd_cnt), 64'd0);
    check_eq("clr_err", 64'(err), 64'd0);

    // read counter saturation
    core_read(7'd5, 1'b0);
    for (int i = 0; i < 65534; i++) step();
    check_eq("sat_fffe", 64'(rd_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) step();
    check_eq("sat_ffff", 64'(rd_cnt), 64'hFFFF);
    check_eq("sat_wr_cnt", 64'(wr_cnt), 64'd0);

    // reset with a host read parked in WAIT: request dropped, memory kept
    host_drive(1'b0, 7'd9, 32'h0);
    step();
    bus.h_req = 1'b0;
    rst = 1'b1;
    core_idle();
    step();
    rst = 1'b0;
    check_eq("wrst_rd_cnt", 64'(rd_cnt), 64'd0);
    check_eq("wrst_h_rdata", 64'(bus.h_rdata), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrst_no_ack", 64'(bus.h_ack), 64'd0);
      step();
    end
    core_read(7'd9, 1'b0);
    #1;
    check_eq("wrst_mem9", 64'(bus.Q), 64'h12345678);
    step();
    core_idle();

    // FSM is back in IDLE: a fresh host write completes with normal latency
    host_drive(1'b1, 7'd127, 32'hA5A5_0F0F);
    step();
    bus.h_req = 1'b0;
    check_eq("post_ack_c1", 64'(bus.h_ack), 64'd0);
    step();
    check_eq("post_ack_c2", 64'(bus.h_ack), 64'd1);
    step();
    core_read(7'd127, 1'b0);
    #1;
    check_eq("post_mem127", 64'(bus.Q), 64'hA5A50F0F);
    step();
    core_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS data port (CEN/WEN/OEN/A/write-data/ReadDataMem): the slave end of the interface the core drives.
- Holds a DEPTH x DW array with a combinational read path and a write on the clock edge.
- Adds a host preload/dump port, served only in cycles where the core leaves the memory idle, using a request/ack FSM.
- Adds saturating access counters and a sticky protocol-error flag for bench and debug use.

Parameters:
AW, 7, address width; matches the core's A[6:0] word address
DW, 32, data width
DEPTH, 128, number of words (2**AW)
CNT_W, 16, width of the read and write access counters

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset: synchronous, active-high
CEN  input  1  chip enable, active low; 0 = core access this cycle
WEN  input  1  1 = read, 0 = write (meaningful only when CEN=0)
OEN  input  1  output enable, active low; must be 0 during core reads
A  input  AW  core word address
D  input  DW  core write data (the core's ReadData2)
Q  output  DW  read data to the core (the core's ReadDataMem)
h_req  input  1  host request
h_we  input  1  host write (1) or read (0)
h_addr  input  AW  host address
h_wdata  input  DW  host write data
h_ack  output  1  one-cycle completion pulse
h_rdata  output  DW  host read data, valid while h_ack=1
clr_cnt  input  1  synchronous clear of the counters and err
rd_cnt  output  CNT_W  core read count
wr_cnt  output  CNT_W  core write count
err  output  1  sticky flag: a core read occurred with OEN=1

Behaviour:
- Reset (rst=1 at a rising edge):
  - FSM goes to IDLE.
  - h_ack=0, h_rdata=0, rd_cnt=0, wr_cnt=0, err=0, q_hold=0.
  - Array contents are not cleared.
  - Reset while the FSM is in WAIT or ACK drops the captured request with no access and no ack.
- Core read (CEN=0, WEN=1):
  - With OEN=0: Q=mem[A], combinational, same cycle.
  - With OEN=1: Q=0 and err is set at the edge.
  - At the edge, q_hold <= Q and rd_cnt increments.
- Core write (CEN=0, WEN=0):
  - mem[A] <= D at the edge; wr_cnt increments; OEN is ignored.
  - A read of the same address in the next cycle returns the new data.
- Outside core read cycles, Q=q_hold (the last core read value).
- Counters:
  - Saturate at 2**CNT_W-1 and never wrap.
  - clr_cnt=1 zeroes rd_cnt, wr_cnt and err; clear wins over a same-cycle increment or error.
- Host FSM, three states:
  - IDLE: when h_req=1, latch h_we, h_addr and h_wdata, then go to WAIT. No access happens in the capture cycle.
  - WAIT: in any cycle with CEN=1, perform the latched access at the edge (write mem, or h_rdata <= mem[addr]) and go to ACK. While CEN=0, stay in WAIT indefinitely; the core is never stalled and has absolute priority.
  - ACK: h_ack=1 for exactly one cycle, then go to IDLE unconditionally. h_rdata holds until the next host read completes.
- Host handshake rules:
  - A new request is captured only in IDLE. h_req still high in ACK is ignored; it is re-sampled in the following IDLE cycle.
  - Minimum host latency is request, then access, then ack: h_ack arrives 2 cycles after h_req is sampled.
  - Host and core never access the array in the same cycle, so there is no same-address conflict.
- Address width: A and h_addr are exactly AW bits, so no range check is needed. Reads of never-written words return X, and benches must preload first.

Test Plan:
- Host write mem[5]=32'hDEADBEEF with CEN=1 throughout -> h_ack pulses 2 cycles after h_req, for 1 cycle; then core read A=5, OEN=0 gives Q=32'hDEADBEEF the same cycle, and rd_cnt=1.
- Core write A=9, D=32'h12345678, then read A=9 next cycle -> Q=32'h12345678, wr_cnt=1, rd_cnt=1; afterwards with CEN=1, Q still 32'h12345678.
- Host read of addr 9 issued while the core holds CEN=0 for 6 cycles -> FSM stays in WAIT, no h_ack; CEN=1 on cycle 7 gives h_ack next cycle with h_rdata=32'h12345678.
- Core read with OEN=1 -> Q=0, err=1 and stays 1; clr_cnt=1 with a simultaneous core read -> rd_cnt=0, err=0.
- Preset rd_cnt to 16'hFFFE via 65534 reads, then 3 more reads -> rd_cnt=16'hFFFF, no wrap.
- rst=1 while the FSM is in WAIT -> next cycle IDLE, h_ack never asserts, counters 0, previously written mem[9] still reads 32'h12345678.
